// File: rtl/lcd_bus_driver_if.sv
// Write handshake between the text/format stage (master) and the LCD bus
// timing engine (slave).
//   wr_valid  master->slave  byte available
//   wr_rs     master->slave  0 = command, 1 = character
//   wr_data   master->slave  byte to write
//   wr_ready  slave->master  engine accepts a byte this cycle
interface lcd_bus_driver_if;
    logic       wr_valid;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       wr_ready;

    modport master (output wr_valid, output wr_rs, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_rs, input wr_data, output wr_ready);
endinterface

// File: rtl/lcd_bus_driver.sv
// HD44780-compatible 8-bit parallel bus timing engine.
// Runs the power-on init sequence, then accepts one byte per valid/ready
// handshake and strobes it onto the LCD bus with setup / enable-high / hold
// timing, followed by the controller execution wait.
// Ports:
//   CLK        system clock
//   RST        asynchronous active-low reset
//   wr         write handshake (slave side of lcd_bus_driver_if)
//   init_done  power-on init complete (sticky until reset)
//   busy       high whenever wr_ready is low
//   RS         LCD register select (registered)
//   EN_OUT     LCD enable strobe (registered)
//   data       LCD data bus (registered)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_PWRUP | power-up delay after reset, no bus activity
// S_SETUP | RS/data driven, EN_OUT low
// S_EN_HI | EN_OUT high
// S_HOLD  | EN_OUT low, RS/data held
// S_EXEC  | controller execution wait (length depends on byte)
// S_IDLE  | waiting for an upstream byte (after init completes)
module lcd_bus_driver #(
    parameter int unsigned PWRUP_CYC     = 2_000_000,
    parameter int unsigned INIT_WAIT_CYC = 500_000,
    parameter int unsigned SETUP_CYC     = 8,
    parameter int unsigned EN_HIGH_CYC   = 50,
    parameter int unsigned HOLD_CYC      = 8,
    parameter int unsigned EXEC_CYC      = 5000,
    parameter int unsigned CLEAR_CYC     = 200_000
) (
    input  logic             CLK,
    input  logic             RST,
    lcd_bus_driver_if.slave  wr,
    output logic             init_done,
    output logic             busy,
    output logic             RS,
    output logic             EN_OUT,
    output logic [7:0]       data
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Zero-length phases are not allowed; a 0 parameter behaves as 1.
    localparam int unsigned P_PWR   = (PWRUP_CYC     == 0) ? 1 : PWRUP_CYC;
    localparam int unsigned P_INIT  = (INIT_WAIT_CYC == 0) ? 1 : INIT_WAIT_CYC;
    localparam int unsigned P_SETUP = (SETUP_CYC     == 0) ? 1 : SETUP_CYC;
    localparam int unsigned P_ENH   = (EN_HIGH_CYC   == 0) ? 1 : EN_HIGH_CYC;
    localparam int unsigned P_HOLD  = (HOLD_CYC      == 0) ? 1 : HOLD_CYC;
    localparam int unsigned P_EXEC  = (EXEC_CYC      == 0) ? 1 : EXEC_CYC;
    localparam int unsigned P_CLEAR = (CLEAR_CYC     == 0) ? 1 : CLEAR_CYC;

    localparam int unsigned MAX_LEN = max2(max2(max2(P_PWR, P_INIT), max2(P_SETUP, P_ENH)),
                                           max2(max2(P_HOLD, P_EXEC), P_CLEAR));
    localparam int CW = $clog2(MAX_LEN) + 1;

    // Down-counter load values: a phase of N cycles loads N-1 and ends at 0.
    localparam logic [CW-1:0] L_PWR   = CW'(P_PWR   - 1);
    localparam logic [CW-1:0] L_INIT  = CW'(P_INIT  - 1);
    localparam logic [CW-1:0] L_SETUP = CW'(P_SETUP - 1);
    localparam logic [CW-1:0] L_ENH   = CW'(P_ENH   - 1);
    localparam logic [CW-1:0] L_HOLD  = CW'(P_HOLD  - 1);
    localparam logic [CW-1:0] L_EXEC  = CW'(P_EXEC  - 1);
    localparam logic [CW-1:0] L_CLEAR = CW'(P_CLEAR - 1);

    localparam logic [2:0] LAST_INIT = 3'd6;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_SETUP,
        S_EN_HI,
        S_HOLD,
        S_EXEC,
        S_IDLE
    } state_t;

    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: return 8'h30;
            3'd3:             return 8'h38;
            3'd4:             return 8'h0C;
            3'd5:             return 8'h06;
            default:          return 8'h01;
        endcase
    endfunction

    state_t          state_q, state_nx;
    logic [CW-1:0]   cnt_q, cnt_nx;
    logic [2:0]      ptr_q, ptr_nx;
    logic            rs_nx, en_nx, ready_nx, done_nx;
    logic [7:0]      data_nx;
    logic [CW-1:0]   exec_load;
    logic            cnt_tc;

    assign cnt_tc = (cnt_q == '0);
    assign busy   = ~wr.wr_ready;

    // Execution wait for the byte currently on the bus.
    always_comb begin
        exec_load = L_EXEC;
        if (!init_done && ptr_q == 3'd0) begin
            exec_load = L_INIT;
        end else if (!RS && (data inside {8'h01, 8'h02, 8'h03})) begin
            exec_load = L_CLEAR;
        end
    end

    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_tc ? cnt_q : cnt_q - CW'(1);
        ptr_nx   = ptr_q;
        rs_nx    = RS;
        data_nx  = data;
        done_nx  = init_done;

        case (state_q)
            S_PWRUP: begin
                if (cnt_tc) begin
                    state_nx = S_SETUP;
                    cnt_nx   = L_SETUP;
                    ptr_nx   = 3'd0;
                    rs_nx    = 1'b0;
                    data_nx  = init_rom(3'd0);
                end
            end
            S_SETUP: begin
                if (cnt_tc) begin
                    state_nx = S_EN_HI;
                    cnt_nx   = L_ENH;
                end
            end
            S_EN_HI: begin
                if (cnt_tc) begin
                    state_nx = S_HOLD;
                    cnt_nx   = L_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_tc) begin
                    state_nx = S_EXEC;
                    cnt_nx   = exec_load;
                end
            end
            S_EXEC: begin
                if (cnt_tc) begin
                    if (init_done) begin
                        state_nx = S_IDLE;
                    end else if (ptr_q == LAST_INIT) begin
                        state_nx = S_IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = S_SETUP;
                        cnt_nx   = L_SETUP;
                        ptr_nx   = ptr_q + 3'd1;
                        rs_nx    = 1'b0;
                        data_nx  = init_rom(ptr_q + 3'd1);
                    end
                end
            end
            S_IDLE: begin
                cnt_nx = cnt_q;
                if (wr.wr_valid && wr.wr_ready) begin
                    state_nx = S_SETUP;
                    cnt_nx   = L_SETUP;
                    rs_nx    = wr.wr_rs;
                    data_nx  = wr.wr_data;
                end
            end
            default: begin
                state_nx = S_PWRUP;
                cnt_nx   = L_PWR;
            end
        endcase

        // Strobe and ready are decoded from the next state so they come
        // straight out of flops.
        en_nx    = (state_nx == S_EN_HI);
        ready_nx = (state_nx == S_IDLE) && done_nx;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_PWRUP;
            cnt_q       <= L_PWR;   // power-up interval starts counting at release
            ptr_q       <= 3'd0;
            RS          <= 1'b0;
            data        <= 8'h00;
            EN_OUT      <= 1'b0;
            wr.wr_ready <= 1'b0;
            init_done   <= 1'b0;
        end else begin
            state_q     <= state_nx;
            cnt_q       <= cnt_nx;
            ptr_q       <= ptr_nx;
            RS          <= rs_nx;
            data        <= data_nx;
            EN_OUT      <= en_nx;
            wr.wr_ready <= ready_nx;
            init_done   <= done_nx;
        end
    end

endmodule
